xidoo_io_unit: RTL and testbench
================================

Name: xidoo_io_unit

Overview:
Parametrised front-panel I/O unit for the xidoo core, replacing direct SWT/Enter/LEDs wiring. Synchronises and debounces the Enter push button and captures the SWT word on each debounced press into a small FIFO. The core drains the FIFO over a valid/ready handshake and drives LEDs through a write-enabled output register. Halt from the core freezes the panel.

Parameters:
DATA_W, 8, width of SWT, InData, OutData and LEDs
FIFO_DEPTH, 4, capture FIFO entries; power of two, >= 2
DB_CYCLES, 4, consecutive stable cycles needed to accept an Enter change; >= 1

Ports:
CLK  in  1  master clock, rising edge
RST  in  1  master reset, asynchronous, active-low
SWT  in  DATA_W  switch word, asynchronous to CLK
Enter  in  1  raw push button, asynchronous, bouncy
Halt  in  1  core halted; freezes capture and LED writes
InValid  out  1  FIFO not empty; InData is valid
InData  out  DATA_W  FIFO head value
InReady  in  1  core accepts head; pop when InValid & InReady
OutWe  in  1  LED register write enable
OutData  in  DATA_W  LED write data
LEDs  out  DATA_W  LED register
Full  out  1  FIFO holds FIFO_DEPTH entries
Count  out  $clog2(FIFO_DEPTH)+1  current occupancy
Overrun  out  1  sticky: a press was dropped because FIFO was full

Behaviour:
- Reset (RST=0, asynchronous): LEDs=0, InValid=0, InData=0, Full=0, Count=0, Overrun=0. Sync flops=0, debounced Enter=0, debounce counter=0, FIFO pointers=0. Release is taken at the next CLK edge. Reset mid-operation discards FIFO contents and any debounce in progress.
- Sync: Enter and SWT each pass through 2 flops before use.
- Debounce:
  - Counter counts cycles in which the synced Enter differs from the debounced state.
  - Any cycle in which they match clears the counter.
  - When the counter reaches DB_CYCLES, the debounced state toggles and the counter clears.
  - Glitches shorter than DB_CYCLES are ignored.
- Capture: a rising edge of the debounced Enter with Halt=0 generates one push of the synced SWT. Falling edges do nothing. Holding Enter produces exactly one push.
- Latency: the first CLK edge sampling Enter=1 (held stable) is edge 0. InValid=1 with the new data is seen after edge DB_CYCLES+3.
- FIFO:
  - InData always shows the head entry; it is 0 when empty.
  - Pop happens on any edge where InValid=1 and InReady=1. InReady while empty is ignored.
  - Push while full and no pop that cycle: the value is dropped, Overrun is set, Count stays FIFO_DEPTH.
  - Push and pop on the same edge: both succeed (a full FIFO stays full, no overrun), Count unchanged.
  - Push into an empty FIFO: InValid rises the next cycle; no fall-through in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; Full = (Count == FIFO_DEPTH).
- Overrun clears only on reset.
- LEDs: on each edge where OutWe=1 and Halt=0, LEDs <= OutData. OutWe with Halt=1 is ignored.
- Halt: pushes and LED writes are blocked. Pops are still allowed. Debouncing continues, so a press that completes during Halt is lost and does not fire at Halt release.
- No combinational path from inputs to outputs except InData from the FIFO storage read.

Optional Feature:
XIDOO_IO_ECHO_EN
- Defined: every accepted push also loads the pushed value into LEDs on the same edge.
  - Pushes dropped on overrun are still echoed.
  - OutWe=1 on the same edge wins over the echo.
  - Halt=1 blocks both.
- Undefined: LEDs change only through OutWe.

Test Plan:
All scenarios use DATA_W=8, FIFO_DEPTH=4, DB_CYCLES=2, CLK period 20 ns.
1. Reset: RST=0 for 100 ns with Enter/SWT toggling -> all outputs 0 throughout. After release with no press, InValid stays 0.
2. Single press: SWT=0x06, Enter=1 held 200 ns -> InValid=1 and InData=0x06 exactly 5 edges after first sample. Count=1, one entry only. InReady pulse -> Count=0, InValid=0.
3. Bounce: Enter high 1 cycle, low 1 cycle, high 1 cycle, then low -> no push, Count=0. Enter held 3 cycles -> exactly one push.
4. Overflow: five presses, SWT=0x01..0x05, no pops -> Full=1, Count=4, Overrun=1. Pops return 0x01..0x04 in order, then InValid=0.
5. Full + simultaneous pop/push: FIFO full, InReady=1 on the push edge -> Count stays 4, Overrun stays 0, head advances.
6. Halt/LEDs: OutWe with OutData=0x0F -> LEDs=0x0F. With Halt=1: OutWe=0xAA and a press with SWT=0x0F -> LEDs stay 0x0F, Count unchanged. With XIDOO_IO_ECHO_EN and Halt=0, a press with SWT=0x06 -> LEDs=0x06 on the push edge.

Source files
------------

// File: rtl/xidoo_io_unit_if.sv
// ---------------------------------------------------------------------------
// xidoo_io_unit_if
// Core-side bus of the xidoo front-panel I/O unit.
//   InValid / InData / InReady : capture FIFO drain (valid/ready handshake)
//   OutWe / OutData / LEDs     : LED output register write port and readback
// Modports:
//   slave  - the I/O unit (drives InValid, InData, LEDs)
//   master - the core     (drives InReady, OutWe, OutData)
// ---------------------------------------------------------------------------
interface xidoo_io_unit_if #(
  parameter int DATA_W = 8
);
  logic              InValid;
  logic [DATA_W-1:0] InData;
  logic              InReady;
  logic              OutWe;
  logic [DATA_W-1:0] OutData;
  logic [DATA_W-1:0] LEDs;

  modport slave (
    output InValid,
    output InData,
    output LEDs,
    input  InReady,
    input  OutWe,
    input  OutData
  );

  modport master (
    input  InValid,
    input  InData,
    input  LEDs,
    output InReady,
    output OutWe,
    output OutData
  );
endinterface

// File: rtl/xidoo_io_unit.sv
// ---------------------------------------------------------------------------
// xidoo_io_unit
// Front-panel I/O unit for the xidoo core. The Enter push button is
// synchronised and debounced; every debounced press captures the
// synchronised SWT word into a small FIFO that the core drains over a
// valid/ready handshake. The core drives the LEDs through a write-enabled
// output register. Halt from the core blocks captures and LED writes.
//
// Parameters:
//   DATA_W     - width of SWT, InData, OutData and LEDs
//   FIFO_DEPTH - capture FIFO entries (power of two, >= 2)
//   DB_CYCLES  - consecutive differing synced cycles that accept an Enter
//                change (>= 1)
//
// Ports:
//   CLK     in   master clock, rising edge
//   RST     in   asynchronous active-low reset
//   SWT     in   switch word, asynchronous to CLK
//   Enter   in   raw push button, asynchronous, bouncy
//   Halt    in   core halted: blocks pushes and LED writes, pops still work
//   io      -    slave side of xidoo_io_unit_if
//                (InValid, InData, InReady, OutWe, OutData, LEDs)
//   Full    out  FIFO holds FIFO_DEPTH entries
//   Count   out  FIFO occupancy
//   Overrun out  sticky: a press was dropped because the FIFO was full
//
// Build option:
//   XIDOO_IO_ECHO_EN - when defined, every push request (accepted or dropped
//   on overrun) also loads the pushed value into LEDs; an OutWe write on the
//   same edge takes priority, and Halt blocks both.
// ---------------------------------------------------------------------------
module xidoo_io_unit #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DB_CYCLES  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_W-1:0]             SWT,
  input  logic                          Enter,
  input  logic                          Halt,
  xidoo_io_unit_if.slave                io,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Count,
  output logic                          Overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DB_W  = $clog2(DB_CYCLES + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  // The counter holds 0..DB_CYCLES-1; the edge that finds it at
  // DB_CYCLES-1 with a still-differing input is the DB_CYCLES-th one.
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);

  // ---------------- state ----------------
  logic              enter_meta_q, enter_meta_d;
  logic              enter_sync_q, enter_sync_d;
  logic [DATA_W-1:0] swt_meta_q,   swt_meta_d;
  logic [DATA_W-1:0] swt_sync_q,   swt_sync_d;

  logic [DB_W-1:0]   db_cnt_q,     db_cnt_d;
  logic              db_state_q,   db_state_d;
  logic              press_q,      press_d;
  logic              push_q,       push_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0]  count_q,      count_d;
  logic              valid_q,      valid_d;
  logic              full_q,       full_d;
  logic              overrun_q,    overrun_d;

  logic [DATA_W-1:0] leds_q,       leds_d;

  // ---------------- handshake terms ----------------
  logic pop_s;
  logic push_req_s;
  logic push_ok_s;

  // Two-flop synchronisers for the asynchronous panel inputs.
  always_comb begin
    enter_meta_d = Enter;
    enter_sync_d = enter_meta_q;
    swt_meta_d   = SWT;
    swt_sync_d   = swt_meta_q;
  end

  // Debounce: count consecutive cycles where the synced button differs from
  // the accepted state; toggle on the DB_CYCLES-th one. A rising toggle is
  // carried through press_q and push_q so the capture lands a fixed number
  // of edges after the toggle.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_state_d = db_state_q;
    press_d    = 1'b0;
    push_d     = press_q;
    if (enter_sync_q != db_state_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_state_d = enter_sync_q;
        db_cnt_d   = '0;
        press_d    = enter_sync_q;
      end else begin
        db_cnt_d   = db_cnt_q + DB_ONE;
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Handshake decode: a pop needs a valid head; a push request is blocked by
  // Halt and only dropped when full with no pop freeing a slot this edge.
  always_comb begin
    pop_s      = valid_q & io.InReady;
    push_req_s = push_q & ~Halt;
    push_ok_s  = push_req_s & (~full_q | pop_s);
  end

  // Capture FIFO storage, pointers, occupancy and status flags.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (push_ok_s) begin
      mem_d[wr_ptr_q] = swt_sync_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (push_req_s && !push_ok_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    // Flags are registered from the next occupancy so they line up with Count.
    valid_d = (count_d != '0);
    full_d  = (count_d == DEPTH_C);
  end

  // LED output register: OutWe has priority over the optional push echo.
  always_comb begin
    leds_d = leds_q;
    if (Halt) begin
      leds_d = leds_q;
    end else if (io.OutWe) begin
      leds_d = io.OutData;
`ifdef XIDOO_IO_ECHO_EN
    end else if (push_req_s) begin
      leds_d = swt_sync_q;
`endif
    end else begin
      leds_d = leds_q;
    end
  end

  // All state flops, cleared asynchronously by RST.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      enter_meta_q <= 1'b0;
      enter_sync_q <= 1'b0;
      swt_meta_q   <= '0;
      swt_sync_q   <= '0;
      db_cnt_q     <= '0;
      db_state_q   <= 1'b0;
      press_q      <= 1'b0;
      push_q       <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      leds_q       <= '0;
    end else begin
      enter_meta_q <= enter_meta_d;
      enter_sync_q <= enter_sync_d;
      swt_meta_q   <= swt_meta_d;
      swt_sync_q   <= swt_sync_d;
      db_cnt_q     <= db_cnt_d;
      db_state_q   <= db_state_d;
      press_q      <= press_d;
      push_q       <= push_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      full_q       <= full_d;
      overrun_q    <= overrun_d;
      leds_q       <= leds_d;
    end
  end

  // Outputs: everything registered except InData, which is the storage read
  // of the head entry (forced to zero while empty).
  assign io.InValid = valid_q;
  assign io.InData  = valid_q ? mem_q[rd_ptr_q] : '0;
  assign io.LEDs    = leds_q;
  assign Full       = full_q;
  assign Count      = count_q;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_xidoo_io_unit.sv
// ---------------------------------------------------------------------------
// tb_xidoo_io_unit
// Self-checking bench for xidoo_io_unit (DATA_W=8, FIFO_DEPTH=4,
// DB_CYCLES=2, 20 ns clock). Hand-written sequences cover reset, latency,
// bounce rejection, overflow, full push/pop and Halt/LED behaviour; a table
// of LED write vectors follows; a randomized phase is compared every cycle
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_xidoo_io_unit;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int DB     = 2;
  localparam int HIST   = 4096;
`ifdef XIDOO_IO_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] SWT = 8'h00;
  logic       Enter = 1'b0;
  logic       Halt = 1'b0;
  logic       Full;
  logic [2:0] Count;
  logic       Overrun;

  xidoo_io_unit_if #(.DATA_W(DATA_W)) io ();

  xidoo_io_unit #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(DEPTH),
    .DB_CYCLES (DB)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SWT    (SWT),
    .Enter  (Enter),
    .Halt   (Halt),
    .io     (io),
    .Full   (Full),
    .Count  (Count),
    .Overrun(Overrun)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Edge n counts rising CLK edges since reset release. The debouncer sees
  // the Enter value sampled two edges earlier; once the button has differed
  // from the accepted level for DB edges the level changes, and a new high
  // level turns into a capture two edges later, using the SWT value that
  // reached the synchroniser output by then.
  logic [7:0] mq[$];
  bit         m_ovr;
  logic [7:0] m_leds;
  bit         m_db;
  int         m_run;
  int         n;
  bit         enter_h [HIST];
  logic [7:0] swt_h   [HIST];
  bit         push_at [HIST + 4];

  task automatic model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_leds = 8'h00;
    m_db   = 1'b0;
    m_run  = 0;
    n      = 0;
    for (int i = 0; i < HIST + 4; i++) push_at[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit         pop;
    bit         push_req;
    bit         was_full;
    bit         seen;
    logic [7:0] pv;
    if (n >= HIST - 1) return;
    enter_h[n] = Enter;
    swt_h[n]   = SWT;
    pop        = (mq.size() != 0) && io.InReady;
    push_req   = push_at[n] && !Halt;
    pv         = (n >= 2) ? swt_h[n-2] : 8'h00;
    was_full   = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (push_req) begin
      if (!was_full || pop) mq.push_back(pv);
      else m_ovr = 1'b1;
    end
    if (!Halt) begin
      if (io.OutWe) m_leds = io.OutData;
      else if (ECHO && push_req) m_leds = pv;
    end
    seen = (n >= 2) ? enter_h[n-2] : 1'b0;
    if (seen != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db  = seen;
        m_run = 0;
        if (seen) push_at[n+2] = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    n++;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (RST) model_edge();
    #1;
  endtask

  task automatic cmp_all(input string tag);
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    check({tag, "_valid"},   32'(io.InValid), 32'(mq.size() != 0));
    check({tag, "_data"},    32'(io.InData),  32'(head));
    check({tag, "_count"},   32'(Count),      32'(mq.size()));
    check({tag, "_full"},    32'(Full),       32'(mq.size() == DEPTH));
    check({tag, "_overrun"}, 32'(Overrun),    32'(m_ovr));
    check({tag, "_leds"},    32'(io.LEDs),    32'(m_leds));
  endtask

  task automatic do_reset(input bit with_checks);
    RST = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      Enter = 1'($urandom);
      SWT   = 8'($urandom);
      step();
      if (with_checks)
        check("reset_outputs_zero",
              32'({io.InValid, io.InData, io.LEDs, Count, Full, Overrun}), 32'h0);
    end
    Enter = 1'b0;
    SWT   = 8'h00;
    RST   = 1'b1;
  endtask

  task automatic press(input logic [7:0] v, input int hold);
    SWT   = v;
    Enter = 1'b1;
    repeat (hold) step();
    Enter = 1'b0;
    repeat (6) step();
  endtask

  task automatic pop_one();
    io.InReady = 1'b1;
    step();
    io.InReady = 1'b0;
  endtask

  typedef struct {
    logic       halt;
    logic       we;
    logic [7:0] data;
    logic [7:0] exp_leds;
  } led_vec_t;

  led_vec_t tbl [7];

  initial begin
    tbl[0] = '{halt: 1'b0, we: 1'b1, data: 8'h3C, exp_leds: 8'h3C};
    tbl[1] = '{halt: 1'b0, we: 1'b0, data: 8'hFF, exp_leds: 8'h3C};
    tbl[2] = '{halt: 1'b1, we: 1'b1, data: 8'h55, exp_leds: 8'h3C};
    tbl[3] = '{halt: 1'b0, we: 1'b1, data: 8'h55, exp_leds: 8'h55};
    tbl[4] = '{halt: 1'b1, we: 1'b0, data: 8'h00, exp_leds: 8'h55};
    tbl[5] = '{halt: 1'b0, we: 1'b1, data: 8'h00, exp_leds: 8'h00};
    tbl[6] = '{halt: 1'b0, we: 1'b1, data: 8'hFF, exp_leds: 8'hFF};

    io.InReady = 1'b0;
    io.OutWe   = 1'b0;
    io.OutData = 8'h00;

    // 1. reset with toggling inputs, then idle
    do_reset(1'b1);
    repeat (8) step();
    check("idle_no_valid", 32'(io.InValid), 32'h0);

    // 2. single press, latency DB+3
    SWT   = 8'h06;
    Enter = 1'b1;
    repeat (5) step();
    check("lat_before", 32'(io.InValid), 32'h0);
    step();
    check("lat_valid", 32'(io.InValid), 32'h1);
    check("lat_data",  32'(io.InData),  32'h06);
    check("lat_count", 32'(Count),      32'h1);
    repeat (4) step();
    Enter = 1'b0;
    repeat (8) step();
    check("hold_one_push", 32'(Count), 32'h1);
    pop_one();
    check("pop_count", 32'(Count),      32'h0);
    check("pop_valid", 32'(io.InValid), 32'h0);
    check("pop_data",  32'(io.InData),  32'h0);

    // 3. bounce rejected, 3-cycle hold accepted
    Enter = 1'b1; step();
    Enter = 1'b0; step();
    Enter = 1'b1; step();
    Enter = 1'b0;
    repeat (8) step();
    check("bounce_count", 32'(Count), 32'h0);
    SWT   = 8'h33;
    Enter = 1'b1;
    repeat (3) step();
    Enter = 1'b0;
    repeat (8) step();
    check("hold3_count", 32'(Count),     32'h1);
    check("hold3_data",  32'(io.InData), 32'h33);
    pop_one();

    // 4. overflow
    for (int v = 1; v <= 5; v++) press(8'(v), 4);
    check("ovf_full",    32'(Full),    32'h1);
    check("ovf_count",   32'(Count),   32'h4);
    check("ovf_overrun", 32'(Overrun), 32'h1);
    for (int v = 1; v <= 4; v++) begin
      check("ovf_order", 32'(io.InData), 32'(v));
      pop_one();
    end
    check("ovf_drained", 32'(io.InValid), 32'h0);

    // 5. full FIFO, push and pop on the same edge
    do_reset(1'b0);
    for (int v = 8'h11; v <= 8'h14; v++) press(8'(v), 4);
    check("fp_full_pre", 32'(Count), 32'h4);
    SWT   = 8'h15;
    Enter = 1'b1;
    repeat (5) step();
    io.InReady = 1'b1;
    step();
    io.InReady = 1'b0;
    check("fp_count",   32'(Count),     32'h4);
    check("fp_overrun", 32'(Overrun),   32'h0);
    check("fp_full",    32'(Full),      32'h1);
    check("fp_head",    32'(io.InData), 32'h12);
    Enter = 1'b0;
    repeat (6) step();
    for (int v = 8'h12; v <= 8'h15; v++) begin
      check("fp_drain", 32'(io.InData), 32'(v));
      pop_one();
    end

    // 6. Halt and LEDs
    do_reset(1'b0);
    io.OutWe   = 1'b1;
    io.OutData = 8'h0F;
    step();
    io.OutWe = 1'b0;
    check("led_write", 32'(io.LEDs), 32'h0F);
    Halt       = 1'b1;
    io.OutWe   = 1'b1;
    io.OutData = 8'hAA;
    step();
    io.OutWe = 1'b0;
    press(8'h0F, 4);
    check("halt_leds",  32'(io.LEDs), 32'h0F);
    check("halt_count", 32'(Count),   32'h0);
    Halt = 1'b0;
    repeat (4) step();
    check("halt_release_no_push", 32'(Count), 32'h0);
    SWT   = 8'h06;
    Enter = 1'b1;
    repeat (6) step();
    check("echo_leds",  32'(io.LEDs), ECHO ? 32'h06 : 32'h0F);
    check("echo_count", 32'(Count),   32'h1);
    Enter = 1'b0;
    repeat (6) step();

    // LED write vectors
    for (int i = 0; i < 7; i++) begin
      Halt       = tbl[i].halt;
      io.OutWe   = tbl[i].we;
      io.OutData = tbl[i].data;
      step();
      check("led_vec", 32'(io.LEDs), 32'(tbl[i].exp_leds));
    end
    Halt     = 1'b0;
    io.OutWe = 1'b0;

    // reset from a busy state, then randomized run against the model
    do_reset(1'b1);
    begin
      int enter_left = 0;
      for (int c = 0; c < 900; c++) begin
        if (enter_left == 0) begin
          Enter      = 1'($urandom);
          enter_left = $urandom_range(1, 6);
        end
        enter_left--;
        if ($urandom_range(0, 19) == 0) Halt = ~Halt;
        io.InReady = ($urandom_range(0, 3) == 0);
        io.OutWe   = ($urandom_range(0, 7) == 0);
        io.OutData = 8'($urandom);
        if ($urandom_range(0, 3) == 0) SWT = 8'($urandom);
        step();
        cmp_all("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
